// File: rtl/ahb_dec2.sv
// AHB-Lite 2-slave address decoder with data-phase select register and a
// built-in default slave that answers unmapped active transfers with ERROR.
module ahb_dec2 #(
    parameter int              AW      = 32,
    parameter logic [AW-1:0]   S0_BASE = 32'h0000_0000,
    parameter logic [AW-1:0]   S0_MASK = 32'hF000_0000,
    parameter logic [AW-1:0]   S1_BASE = 32'h1000_0000,
    parameter logic [AW-1:0]   S1_MASK = 32'hF000_0000
) (
    input  logic          hclk,
    input  logic          hresetn,
    input  logic [AW-1:0] haddr,
    input  logic [1:0]    htrans,
    input  logic          hready,
    output logic          hsel0,
    output logic          hsel1,
    output logic          dsel0,
    output logic          dsel1,
    output logic          dseldef,
    output logic          def_hreadyout,
    output logic          def_hresp
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ERR1 = 2'b01,
        ST_ERR2 = 2'b10
    } state_t;

    logic   match0, match1, nomatch, err_req;
    state_t state, state_nxt;

    // Slave 0 wins where the two regions overlap.
    assign match0  = ((haddr & S0_MASK) == S0_BASE);
    assign match1  = ((haddr & S1_MASK) == S1_BASE);
    assign hsel0   = match0;
    assign hsel1   = match1 & ~match0;
    assign nomatch = ~match0 & ~match1;

    // Only NONSEQ/SEQ transfers to unmapped space earn an ERROR response.
    assign err_req = hready & nomatch & htrans[1];

    // Reset selects the default slave so the bus sees a ready OKAY out of reset.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            dsel0   <= 1'b0;
            dsel1   <= 1'b0;
            dseldef <= 1'b1;
        end else if (hready) begin
            dsel0   <= hsel0;
            dsel1   <= hsel1;
            dseldef <= nomatch;
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = ST_IDLE;
        case (state)
            ST_IDLE: state_nxt = err_req ? ST_ERR1 : ST_IDLE;
            ST_ERR1: state_nxt = ST_ERR2;
            ST_ERR2: state_nxt = err_req ? ST_ERR1 : ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        def_hreadyout = 1'b1;
        def_hresp     = 1'b0;
        case (state)
            ST_ERR1: begin
                def_hreadyout = 1'b0;
                def_hresp     = 1'b1;
            end
            ST_ERR2: begin
                def_hreadyout = 1'b1;
                def_hresp     = 1'b1;
            end
            default: begin
                def_hreadyout = 1'b1;
                def_hresp     = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_ahb_dec2.sv
// Directed bench for ahb_dec2: registered outputs checked through a scoreboard
// queue, combinational selects checked directly, one-hot dsel checked each cycle.
module tb_ahb_dec2;

    logic        hclk = 1'b0;
    logic        hresetn = 1'b1;
    logic [31:0] haddr = '0;
    logic [1:0]  htrans = 2'b00;
    logic        hready = 1'b1;
    logic        hsel0, hsel1, dsel0, dsel1, dseldef, def_hreadyout, def_hresp;
    logic        o_hsel0, o_hsel1, o_dsel0, o_dsel1, o_dseldef, o_rdy, o_resp;

    int nvec = 0;
    int nerr = 0;

    // {dsel0, dsel1, dseldef, def_hreadyout, def_hresp}
    logic [4:0] sb[$];

    always #5 hclk = ~hclk;

    ahb_dec2 u_dut (
        .hclk(hclk), .hresetn(hresetn), .haddr(haddr), .htrans(htrans),
        .hready(hready), .hsel0(hsel0), .hsel1(hsel1), .dsel0(dsel0),
        .dsel1(dsel1), .dseldef(dseldef), .def_hreadyout(def_hreadyout),
        .def_hresp(def_hresp)
    );

    ahb_dec2 #(.S1_BASE(32'h0000_0000)) u_ovl (
        .hclk(hclk), .hresetn(hresetn), .haddr(haddr), .htrans(htrans),
        .hready(hready), .hsel0(o_hsel0), .hsel1(o_hsel1), .dsel0(o_dsel0),
        .dsel1(o_dsel1), .dseldef(o_dseldef), .def_hreadyout(o_rdy),
        .def_hresp(o_resp)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] dut_regs();
        return {dsel0, dsel1, dseldef, def_hreadyout, def_hresp};
    endfunction

    // Drive one address phase, check decode, push the expected registered
    // result, clock it, then pop and compare.
    task automatic step(input string tag, input logic [31:0] a, input logic [1:0] t,
                        input logic r, input logic [1:0] exp_hsel, input logic [4:0] exp_reg);
        logic [4:0] e;
        haddr  = a;
        htrans = t;
        hready = r;
        #1;
        chk({tag, "_hsel"}, {30'd0, hsel0, hsel1}, {30'd0, exp_hsel});
        sb.push_back(exp_reg);
        @(posedge hclk);
        #1;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_regs"}, {27'd0, dut_regs()}, {27'd0, e});
        end
    endtask

    always @(negedge hclk) begin
        chk("onehot", 32'(dsel0) + 32'(dsel1) + 32'(dseldef), 32'd1);
    end

    initial begin
        #1 hresetn = 1'b0;
        #1;
        chk("reset_regs", {27'd0, dut_regs()}, {27'd0, 5'b00110});
        @(negedge hclk);
        hresetn = 1'b1;
        @(posedge hclk);
        #1;

        // Mapped decode
        step("map_s0", 32'h0000_0040, 2'b10, 1'b1, 2'b10, 5'b10010);
        step("map_s1", 32'h1000_0040, 2'b10, 1'b1, 2'b01, 5'b01010);

        // Unmapped NONSEQ: ERR1, ERR2, then IDLE
        step("err_nseq", 32'h2000_0000, 2'b10, 1'b1, 2'b00, 5'b00101);
        step("err_err2", 32'h2000_0000, 2'b00, 1'b0, 2'b00, 5'b00111);
        step("err_done", 32'h0000_0000, 2'b00, 1'b1, 2'b10, 5'b10010);

        // Unmapped IDLE and BUSY get OKAY
        step("unm_idle", 32'h3000_0000, 2'b00, 1'b1, 2'b00, 5'b00110);
        step("unm_busy", 32'h3000_0000, 2'b01, 1'b1, 2'b00, 5'b00110);

        // Back-to-back errors
        step("b2b_e1",  32'h2000_0000, 2'b10, 1'b1, 2'b00, 5'b00101);
        step("b2b_e2",  32'h2000_0000, 2'b10, 1'b0, 2'b00, 5'b00111);
        step("b2b_seq", 32'h2000_0004, 2'b11, 1'b1, 2'b00, 5'b00101);
        step("b2b_e2b", 32'h2000_0004, 2'b11, 1'b0, 2'b00, 5'b00111);
        step("b2b_end", 32'h0000_0000, 2'b00, 1'b1, 2'b10, 5'b10010);

        // Wait-state hold
        step("hold_w",  32'h1000_0000, 2'b10, 1'b0, 2'b01, 5'b10010);
        step("hold_w2", 32'h1000_0000, 2'b10, 1'b0, 2'b01, 5'b10010);
        step("hold_go", 32'h1000_0000, 2'b10, 1'b1, 2'b01, 5'b01010);

        // Region boundaries
        step("bnd_s0hi", 32'h0FFF_FFFF, 2'b10, 1'b1, 2'b10, 5'b10010);
        step("bnd_s1hi", 32'h1FFF_FFFF, 2'b10, 1'b1, 2'b01, 5'b01010);
        step("bnd_top",  32'hFFFF_FFFF, 2'b00, 1'b1, 2'b00, 5'b00110);

        // Overlap: slave 0 wins
        haddr = 32'h0000_0010;
        #1;
        chk("ovl_hsel", {30'd0, o_hsel0, o_hsel1}, 32'd2);
        haddr = 32'h1000_0010;
        #1;
        chk("ovl_s1", {30'd0, o_hsel0, o_hsel1}, 32'd0);

        // Async reset in the middle of ERR1
        step("rst_e1", 32'h4000_0000, 2'b10, 1'b1, 2'b00, 5'b00101);
        htrans  = 2'b00;
        hready  = 1'b0;
        hresetn = 1'b0;
        #2;
        chk("rst_mid_err1", {27'd0, dut_regs()}, {27'd0, 5'b00110});
        @(negedge hclk);
        hresetn = 1'b1;
        @(posedge hclk);
        #1;
        step("post_rst", 32'h1000_0000, 2'b10, 1'b1, 2'b01, 5'b01010);

        if (sb.size() != 0) chk("sb_drain", 32'(sb.size()), 32'd0);
        @(posedge hclk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
